f_maxpool_ctrl: RTL and testbench

Max-pooling window sequencer for float streams. It accepts elements over a valid/ready input, folds each window of `windowMinusOne+1` elements with an IEEE-754 sign-magnitude max, and emits one result per window over a valid/ready output. It runs a programmed number of windows and then reports done. It sits between the stream memory interface and the pooling output buffer, replacing free-running stride/delay timing with explicit flow control.

---
 rtl/f_maxpool_pkg.sv | 16 +
 rtl/f_maxpool_ctrl_max2.sv | 32 +++
 rtl/f_maxpool_ctrl.sv | 105 ++++++++++
 tb/tb_f_maxpool_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/f_maxpool_pkg.sv
// f_maxpool_pkg: shared state encoding and float helpers for the max-pool sequencer.
package f_maxpool_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    // Quiet NaN for any layout: exponent all ones, mantissa MSB set.
    function automatic logic [63:0] canon_nan(input int dw, input int ew);
        return (((64'd1 << ew) - 64'd1) << (dw - 1 - ew)) | (64'd1 << (dw - 2 - ew));
    endfunction
    function automatic logic is_nan(input logic [63:0] x, input int dw, input int ew);
        logic [63:0] e_mask;
        logic [63:0] m_mask;
        m_mask = (64'd1 << (dw - 1 - ew)) - 64'd1;
        e_mask = ((64'd1 << ew) - 64'd1) << (dw - 1 - ew);
        return ((x & e_mask) == e_mask) && ((x & m_mask) != 64'd0);
    endfunction
endpackage

// File: rtl/f_maxpool_ctrl_max2.sv
// f_max2: combinational sign-magnitude float max; keeps i_a on ties.
// With F_MAXPOOL_NAN_PROP_EN it also flags a NaN on i_b.
module f_max2 #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
`ifdef F_MAXPOOL_NAN_PROP_EN
    output logic              o_nan,
`endif
    output logic [DATA_W-1:0] o_y
);
`ifdef F_MAXPOOL_NAN_PROP_EN
    import f_maxpool_pkg::*;
`endif
    localparam int MAN_W = DATA_W - 1 - EXP_W;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_ma, w_mb;
    logic             w_b_gt, w_b_lt, w_b_wins;
    assign {w_ea, w_ma} = i_a[DATA_W-2:0];
    assign {w_eb, w_mb} = i_b[DATA_W-2:0];
    assign w_b_gt = (w_eb != w_ea) ? (w_eb > w_ea) : (w_mb > w_ma);
    assign w_b_lt = (w_eb != w_ea) ? (w_eb < w_ea) : (w_mb < w_ma);
    // Differing signs: b wins exactly when a is the negative one.
    assign w_b_wins = (i_a[DATA_W-1] != i_b[DATA_W-1]) ? i_a[DATA_W-1]
                    : (i_a[DATA_W-1] ? w_b_lt : w_b_gt);
    assign o_y = w_b_wins ? i_b : i_a;
`ifdef F_MAXPOOL_NAN_PROP_EN
    assign o_nan = is_nan(64'(i_b), DATA_W, EXP_W);
`endif
endmodule

// File: rtl/f_maxpool_ctrl.sv
// f_maxpool_ctrl: valid/ready max-pool window sequencer for float streams.
// Define F_MAXPOOL_NAN_PROP_EN to force any window containing a NaN to the canonical quiet NaN.
module f_maxpool_ctrl
    import f_maxpool_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8,
    parameter int CNT_W  = 7,
    parameter int WIN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              running,
    input  logic [CNT_W-1:0]  windowMinusOne,
    input  logic [WIN_W-1:0]  numWindows,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              done
);
    state_t            r_state;
    logic [CNT_W-1:0]  r_wm1, r_elem_cnt;
    logic [WIN_W-1:0]  r_nwin, r_win_cnt;
    logic [DATA_W-1:0] r_acc, r_out_data;
    logic              r_out_valid, r_done;
    logic [DATA_W-1:0] w_max, w_next, w_result;
    logic              w_first, w_last, w_accept;
`ifdef F_MAXPOOL_NAN_PROP_EN
    logic              r_nan, w_in_nan, w_win_nan;
`endif
    assign w_first  = r_elem_cnt == '0;
    assign w_last   = r_elem_cnt == r_wm1;
    // A last element may only land once the output slot is free or emptying now.
    assign in_ready = (r_state == ACCUM) && running && !(w_last && r_out_valid && !out_ready);
    assign w_accept = in_valid && in_ready;
    f_max2 #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_max (
        .i_a   (r_acc),
        .i_b   (in_data),
`ifdef F_MAXPOOL_NAN_PROP_EN
        .o_nan (w_in_nan),
`endif
        .o_y   (w_max)
    );
    assign w_next = w_first ? in_data : w_max;
`ifdef F_MAXPOOL_NAN_PROP_EN
    assign w_win_nan = w_in_nan || (!w_first && r_nan);
    assign w_result  = w_win_nan ? DATA_W'(canon_nan(DATA_W, EXP_W)) : w_next;
`else
    assign w_result  = w_next;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_wm1       <= '0;
            r_nwin      <= '0;
            r_elem_cnt  <= '0;
            r_win_cnt   <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
`ifdef F_MAXPOOL_NAN_PROP_EN
            r_nan       <= 1'b0;
`endif
        end else if (run) begin
            r_wm1       <= windowMinusOne;
            r_nwin      <= numWindows;
            r_elem_cnt  <= '0;
            r_win_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_done      <= numWindows == '0;
            r_state     <= (numWindows == '0) ? DONE : ACCUM;
        end else begin
            if (r_out_valid && out_ready)
                r_out_valid <= 1'b0;
            if (w_accept) begin
                r_acc <= w_next;
`ifdef F_MAXPOOL_NAN_PROP_EN
                r_nan <= w_win_nan;
`endif
                if (w_last) begin
                    r_elem_cnt  <= '0;
                    r_win_cnt   <= r_win_cnt + WIN_W'(1);
                    r_out_data  <= w_result;
                    r_out_valid <= 1'b1;
                    if (r_win_cnt == r_nwin - WIN_W'(1))
                        r_state <= DRAIN;
                end else begin
                    r_elem_cnt <= r_elem_cnt + CNT_W'(1);
                end
            end
            if (r_state == DRAIN && (!r_out_valid || out_ready)) begin
                r_state <= DONE;
                r_done  <= 1'b1;
            end
        end
    end
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign done      = r_done;
endmodule

// File: tb/tb_f_maxpool_ctrl.sv
// tb_f_maxpool_ctrl: scoreboard bench for f_maxpool_ctrl with a float-ordering reference model.
module tb_f_maxpool_ctrl;
    logic        clk = 0;
    logic        rst = 0;
    logic        run = 0;
    logic        running = 1;
    logic [6:0]  windowMinusOne = 0;
    logic [15:0] numWindows = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] in_data = 0;
    logic        out_valid;
    logic        out_ready = 1;
    logic [31:0] out_data;
    logic        done;

    int checks = 0, errors = 0;
    int rmode = 0, hold = 0, stall_n = 0, run_len = 0, max_run = 0;
    bit trig = 0;
    logic [31:0] exp_q[$];
    logic [31:0] dq[$];

    f_maxpool_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .running(running),
        .windowMinusOne(windowMinusOne), .numWindows(numWindows),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Total order on floats: negatives map below positives; ties between +0/-0 go to +0.
    function automatic longint key(input logic [31:0] x);
        return x[31] ? -longint'({1'b0, x[30:0]}) : longint'({1'b0, x[30:0]});
    endfunction

    function automatic logic [31:0] win_ref(input int s, input int n);
        logic [31:0] r;
        r = dq[s];
        for (int i = s + 1; i < s + n; i++)
            if (key(dq[i]) > key(r) || (key(dq[i]) == key(r) && r[31] && !dq[i][31]))
                r = dq[i];
`ifdef F_MAXPOOL_NAN_PROP_EN
        for (int i = s; i < s + n; i++)
            if (dq[i][30:23] == 8'hFF && dq[i][22:0] != 0)
                r = 32'h7FC0_0000;
`endif
        return r;
    endfunction

    function automatic logic [31:0] rnd_f();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0000_0000;
            1: v = 32'h8000_0000;
            2: v = 32'h7F80_0000;
            3: v = 32'hFF80_0000;
            default: begin
                v = $urandom();
                if (v[30:23] == 8'hFF) v[30] = 1'b0;
            end
        endcase
        return v;
    endfunction

    // Output side: compare every handshake and every stalled cycle against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            run_len = out_valid ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h with no pending result", out_data);
                end else if (out_ready) begin
                    chk("out_data", out_data, exp_q.pop_front());
                end else begin
                    chk("out_hold", out_data, exp_q[0]);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = $urandom_range(0, 2) != 0;
            2: begin
                if (out_valid && !trig) begin
                    trig = 1;
                    hold = 5;
                end
                out_ready = hold == 0;
                if (hold > 0) hold--;
            end
            default: out_ready = 1'b0;
        endcase
    end

    task automatic start(input int wm1, input int nw, input bit flush);
        @(posedge clk);
        #1;
        windowMinusOne = 7'(wm1);
        numWindows = 16'(nw);
        run = 1;
        @(posedge clk);
        #1;
        run = 0;
        if (flush) exp_q.delete();
    endtask

    task automatic feed(input int wm1, input bit push, input bit rnd);
        int idx = 0, guard = 0, bad = 0;
        bit acc;
        if (push)
            for (int s = 0; s + wm1 < dq.size(); s += wm1 + 1)
                exp_q.push_back(win_ref(s, wm1 + 1));
        while (idx < dq.size() && guard < 2000) begin
            in_valid = rnd ? $urandom_range(0, 3) != 0 : 1'b1;
            running = rnd ? $urandom_range(0, 7) != 0 : 1'b1;
            in_data = dq[idx];
            @(negedge clk);
            acc = in_valid && in_ready;
            if (!running && in_ready) bad++;
            if (in_valid && running && !in_ready) begin
                stall_n++;
                if (idx % (wm1 + 1) != wm1) bad++;
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
        end
        in_valid = 0;
        running = 1;
        chk("feed_complete", 32'(idx), 32'(dq.size()));
        chk("ready_rule", 32'(bad), 0);
    endtask

    task automatic wait_done(input bit exact);
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done", 32'(done), 1);
        if (exact) chk("done_latency", 32'(n), 2);
        chk("drained", 32'(exp_q.size()), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_data", out_data, 0);
        rst = 1;

        dq = {};
        dq.push_back(32'h3F80_0000); dq.push_back(32'hC000_0000);
        dq.push_back(32'h4060_0000); dq.push_back(32'h3F00_0000);
        dq.push_back(32'hBF80_0000); dq.push_back(32'hC080_0000);
        dq.push_back(32'hBF00_0000); dq.push_back(32'hC040_0000);
        start(3, 2, 0);
        feed(3, 1, 0);
        wait_done(1);

        dq = {};
        dq.push_back(32'd7); dq.push_back(32'd8); dq.push_back(32'd9);
        max_run = 0;
        start(0, 3, 0);
        feed(0, 1, 0);
        wait_done(1);
        chk("valid_run", 32'(max_run), 3);

        dq = {};
        for (int i = 0; i < 6; i++) dq.push_back(rnd_f());
        rmode = 2;
        trig = 0;
        stall_n = 0;
        start(1, 3, 0);
        feed(1, 1, 0);
        wait_done(0);
        chk("stall_seen", 32'(stall_n >= 3), 1);
        rmode = 0;

        dq = {};
        dq.push_back(32'h8000_0000); dq.push_back(32'h0000_0000);
        dq.push_back(32'h0000_0000); dq.push_back(32'h8000_0000);
        start(1, 2, 0);
        feed(1, 1, 0);
        wait_done(1);

        dq = {};
        for (int i = 0; i < 6; i++) dq.push_back(rnd_f());
        rmode = 3;
        start(3, 2, 0);
        feed(3, 1, 0);
        @(negedge clk);
        chk("pending_before_run", 32'(out_valid), 1);
        start(3, 2, 1);
        rmode = 0;
        @(negedge clk);
        chk("run_drops_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        dq = {};
        for (int i = 0; i < 8; i++) dq.push_back(rnd_f());
        feed(3, 1, 0);
        wait_done(1);

        dq = {};
        dq.push_back(32'h3F80_0000); dq.push_back(32'h7F80_0001); dq.push_back(32'h40A0_0000);
        start(2, 1, 0);
        feed(2, 1, 0);
        wait_done(1);

        start(2, 0, 0);
        @(negedge clk);
        chk("zero_windows_done", 32'(done), 1);
        chk("zero_windows_ready", 32'(in_ready), 0);

        for (int j = 0; j < 8; j++) begin
            int wm1, nw;
            wm1 = $urandom_range(0, 5);
            nw = $urandom_range(1, 4);
            dq = {};
            for (int i = 0; i < nw * (wm1 + 1); i++)
                dq.push_back(($urandom_range(0, 4) == 0 && i > 0) ? dq[i-1] : rnd_f());
            rmode = 1;
            start(wm1, nw, 0);
            feed(wm1, 1, 1);
            wait_done(0);
        end

        dq = {};
        for (int i = 0; i < 3; i++) dq.push_back(rnd_f());
        rmode = 3;
        start(1, 3, 0);
        feed(1, 1, 0);
        @(negedge clk);
        chk("pending_before_reset", 32'(out_valid), 1);
        #2;
        rst = 0;
        #1;
        chk("areset_out_valid", 32'(out_valid), 0);
        chk("areset_in_ready", 32'(in_ready), 0);
        chk("areset_done", 32'(done), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1;
        rmode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
